// File: rtl/query_patch_pkg.sv
// query_patch_pkg: shared state encoding, default geometry and index sizing for the query patch writer.
package query_patch_pkg;
    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} qpw_state_t;
    localparam int DEF_DATA_WIDTH = 11;
    localparam int DEF_PATCH_SIZE = 5;
    localparam int PATCH_WIDTH = DEF_DATA_WIDTH * DEF_PATCH_SIZE;
    localparam int IDX_WIDTH = $clog2(DEF_PATCH_SIZE);
    function automatic int idx_width(input int ps);
        return ps > 1 ? $clog2(ps) : 1;
    endfunction
endpackage

// File: rtl/patch_packer.sv
// patch_packer: component index counter and patch register; slot 0 starts a fresh zeroed patch.
module patch_packer import query_patch_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PATCH_SIZE = DEF_PATCH_SIZE,
    localparam int IW = idx_width(PATCH_SIZE),
    localparam int PW = DATA_WIDTH * PATCH_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  insert,
    input  logic                  pad,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [IW-1:0]         idx,
    output logic [PW-1:0]         patch
);
    logic [PW-1:0] next_patch;
    always_comb begin
        next_patch = (idx == '0) ? '0 : patch;
        next_patch[idx*DATA_WIDTH +: DATA_WIDTH] = data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            patch <= '0;
        end else if (clear) begin
            idx   <= '0;
            patch <= '0;
        end else if (insert) begin
            patch <= next_patch;
            idx   <= (pad || idx == IW'(PATCH_SIZE-1)) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/query_patch_writer.sv
// query_patch_writer: packs streamed components into patches and writes them to memory port 0.
// Define QUERY_PATCH_WRITER_PAD_EN to zero-fill and write a partial final patch instead of dropping it.
module query_patch_writer import query_patch_pkg::*; #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512,
    localparam int IW = idx_width(PATCH_SIZE),
    localparam int PW = DATA_WIDTH * PATCH_SIZE,
    localparam int CW = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  wb_mode,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [PW-1:0]         wpatch0,
    output logic [CW-1:0]         patch_count,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    qpw_state_t state;
    logic [IW-1:0] idx;
    logic last_q;
    logic accept;
    logic last_comp;
    logic full;
    assign in_ready  = state == FILL && !wb_mode;
    assign accept    = in_valid && in_ready;
    assign last_comp = idx == IW'(PATCH_SIZE-1);
    assign full      = patch_count == CW'(DEPTH);
    assign csb0      = !(state == WRITE && !wb_mode && !full);
    assign web0      = csb0;
    assign busy      = state == FILL || state == WRITE;
    patch_packer #(.DATA_WIDTH(DATA_WIDTH), .PATCH_SIZE(PATCH_SIZE)) u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start),
        .insert(accept && !start),
        .pad   (in_last),
        .data  (in_data),
        .idx   (idx),
        .patch (wpatch0)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr0       <= '0;
            patch_count <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            last_q      <= 1'b0;
        end else if (start) begin
            state       <= FILL;
            addr0       <= '0;
            patch_count <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            case (state)
                FILL: if (accept) begin
                    if (last_comp) begin
                        state  <= WRITE;
                        last_q <= in_last;
                    end else if (in_last) begin
`ifdef QUERY_PATCH_WRITER_PAD_EN
                        state  <= WRITE;
                        last_q <= 1'b1;
`else
                        state    <= DONE;
                        overflow <= 1'b1;
                        done     <= 1'b1;
`endif
                    end
                end
                // a full memory drops the patch at once; otherwise wait for the port
                WRITE: if (full || !wb_mode) begin
                    if (full)
                        overflow <= 1'b1;
                    else begin
                        patch_count <= patch_count + 1'b1;
                        if (addr0 != ADDR_WIDTH'(DEPTH-1))
                            addr0 <= addr0 + 1'b1;
                    end
                    state <= last_q ? DONE : FILL;
                    done  <= last_q;
                end
                default: ;
            endcase
        end
    end
endmodule
